dcache_data_ways: RTL and testbench
===================================

# dcache_data_ways

Parametrised N-way data array for the RV64 data cache, successor to the single-way direct-mapped data store. It holds WAYS banks of LINE_W-bit lines. It applies byte/half/word/double stores through a generated byte-enable mask. It assembles cache-miss refills from narrow memory beats with a valid/ready handshake and commits each completed line in a single cycle. It sits between the cache controller FSM, which supplies way/index/offset, and the memory refill path.

## Interface
- WAYS, 2, number of ways (power of two, ≥1)
- INDEX, 10, index width; depth = 2**INDEX lines per way
- LINE_W, 128, line width in bits (power of two, 64..512)
- BEAT_W, 32, refill beat width; LINE_W % BEAT_W == 0
- XLEN, 64, store data width
- Derived: OFF_W = log2(LINE_W/8); WAY_W = max(1, log2(WAYS)); BEATS = LINE_W/BEAT_W

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- rden  in  1  read request; reads all ways at index
- wren  in  1  store request
- way_sel  in  WAY_W  target way for store
- index  in  INDEX  set index for read/store
- byte_offset  in  OFF_W  byte offset within line
- storesrc  in  2  00 byte, 01 half, 10 word, 11 double
- store_data  in  XLEN  store operand; low bytes used
- rd_data  out  WAYS*LINE_W  way w at [w*LINE_W +: LINE_W]
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  refill commit in progress; store port blocked
- misalign_err  out  1  one-cycle pulse on a dropped misaligned store
- refill_start  in  1  begin line refill
- refill_way  in  WAY_W  way captured at refill_start
- refill_index  in  INDEX  index captured at refill_start
- refill_valid  in  1  beat valid
- refill_data  in  BEAT_W  beat payload; beat 0 = lowest bits
- refill_ready  out  1  block accepts beats
- refill_done  out  1  one-cycle pulse when line is written

## Operation
- Byte mask: size = 1<<storesrc bytes at byte_offset; data replicated into lanes. Aligned only: byte_offset % size != 0 → no write, misalign_err=1 next cycle.
- Store with wren=1 and busy=1 is dropped without error. The controller must hold the store and retry.
- The read is read-first. A store or commit to the same way/index in the same cycle returns the old line; the new data is visible from the following read.
- rden and wren together are both honoured.
- Refill FSM states: IDLE, FILL, COMMIT.
  - IDLE: refill_start → FILL; capture way/index; beat count = 0.
  - FILL: refill_ready=1. Each refill_valid&&refill_ready places refill_data at bits [cnt*BEAT_W +: BEAT_W] of the buffer and increments cnt. Acceptance of beat BEATS-1 → COMMIT.
  - COMMIT: write the full buffer to the captured way/index; busy=1; refill_done=1; → IDLE.
- refill_start outside IDLE is ignored.
- Stores to other lines during FILL proceed normally. A store during FILL to the line being refilled is written, then overwritten by COMMIT; the controller must not issue it.
- The memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: rd_data 0, rd_valid 0, busy 0, misalign_err 0, refill_ready 0, refill_done 0, FSM IDLE, cnt 0.
- Read latency 1: rden at edge N → rd_data/rd_valid after edge N. rd_valid=0 on cycles without rden; rd_data holds its last value.
- Store latency: written at edge N, readable by rden at cycle N+1.
- Refill: start at edge S. First beat acceptable at edge S+1. With valid held, the last beat lands at S+BEATS, COMMIT occupies S+BEATS+1, and refill_done is high in that cycle.
- refill_ready deasserts combinationally with the state in the COMMIT cycle. Gaps in refill_valid stall cnt.
- Reset mid-FILL or mid-COMMIT: the buffer is discarded, no array write occurs, and refill_done does not pulse.

## Structure
- Package dcache_pkg holds the storesrc_e enum (SB, SH, SW, SD), the refill_state_e enum, and a function byte_mask(storesrc, offset) returning LINE_W/8 bits plus an alignment flag.
- Sub-module dcache_refill_buffer holds the FSM, beat counter and shift buffer. It outputs the commit strobe, way, index and line.
- The top level holds the per-way arrays, write muxing and the read register.

## Test plan
- Reset, store double 0x1122334455667788 to way 1, idx 5, off 8; read idx 5 → way1 bits[127:64] = 0x1122334455667788.
- Byte store 0xAB at off 15 over a prefilled 0 line → only bits[127:120] = 0xAB. Half store at off 3 → misalign_err pulse, line unchanged.
- Refill way 0, idx 7 with beats 0xA0,0xA1,0xA2,0xA3 and one valid gap → refill_done 1 cycle after the last beat; read gives 0x000000A3_000000A2_000000A1_000000A0.
- Store in the COMMIT cycle → dropped, busy=1. Same-cycle read of the refilled line returns old data; the next read returns the new line.
- Assert rst after two accepted beats → refill_ready=0, FSM IDLE, target line unchanged, no refill_done.
- Simultaneous rden+wren to the same set → rd_data shows the old value; the next rden shows the store.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and the store byte-mask helper for the data-cache way array.
package dcache_pkg;

  localparam int unsigned MAX_LINE_B = 64;
  localparam int unsigned MAX_OFF_W  = 6;

  typedef enum logic [1:0] {SB = 2'b00, SH = 2'b01, SW = 2'b10, SD = 2'b11} storesrc_e;

  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, COMMIT = 2'b10} refill_state_e;

  typedef struct packed {
    logic [MAX_LINE_B-1:0] mask;
    logic                  aligned;
  } byte_mask_t;

  // Byte lanes touched by a naturally aligned store; mask is only meaningful when aligned.
  function automatic byte_mask_t byte_mask(storesrc_e src, logic [MAX_OFF_W-1:0] offset);
    byte_mask_t            res;
    logic [MAX_LINE_B-1:0] base;
    logic [MAX_OFF_W-1:0]  amask;
    case (src)
      SB:      begin base = MAX_LINE_B'(8'h01); amask = MAX_OFF_W'(0); end
      SH:      begin base = MAX_LINE_B'(8'h03); amask = MAX_OFF_W'(1); end
      SW:      begin base = MAX_LINE_B'(8'h0f); amask = MAX_OFF_W'(3); end
      default: begin base = MAX_LINE_B'(8'hff); amask = MAX_OFF_W'(7); end
    endcase
    res.mask    = base << offset;
    res.aligned = (offset & amask) == '0;
    return res;
  endfunction

endpackage

// File: rtl/dcache_refill_buffer.sv
// Collects refill beats into a line buffer and presents a one-cycle commit.
module dcache_refill_buffer
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned INDEX  = 10,
  parameter int unsigned WAY_W  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WAY_W-1:0]  way_i,
  input  logic [INDEX-1:0]  index_i,
  input  logic              valid_i,
  input  logic [BEAT_W-1:0] data_i,
  output logic              ready_o,
  output logic              commit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [INDEX-1:0]  index_o,
  output logic [LINE_W-1:0] line_o
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  refill_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [INDEX-1:0]  index_q, index_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      index_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      index_q <= index_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    way_d   = way_q;
    index_d = index_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          cnt_d   = '0;
          way_d   = way_i;
          index_d = index_i;
        end
      end
      FILL: begin
        if (valid_i) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = data_i;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register so ready drops in the commit cycle.
  assign ready_o  = (state_q == FILL);
  assign commit_o = (state_q == COMMIT);
  assign way_o    = way_q;
  assign index_o  = index_q;
  assign line_o   = line_q;

endmodule

// File: rtl/dcache_data_ways.sv
// N-way data array: read-first line reads, masked aligned stores and refill commits.
module dcache_data_ways
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned INDEX  = 10,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned XLEN   = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rden,
  input  logic                                  wren,
  input  logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] way_sel,
  input  logic [INDEX-1:0]                      index,
  input  logic [$clog2(LINE_W/8)-1:0]           byte_offset,
  input  logic [1:0]                            storesrc,
  input  logic [XLEN-1:0]                       store_data,
  output logic [WAYS*LINE_W-1:0]                rd_data,
  output logic                                  rd_valid,
  output logic                                  busy,
  output logic                                  misalign_err,
  input  logic                                  refill_start,
  input  logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] refill_way,
  input  logic [INDEX-1:0]                      refill_index,
  input  logic                                  refill_valid,
  input  logic [BEAT_W-1:0]                     refill_data,
  output logic                                  refill_ready,
  output logic                                  refill_done
);

  localparam int unsigned LINE_B = LINE_W / 8;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned DEPTH  = 2 ** INDEX;

  logic [LINE_W-1:0]      mem_q [WAYS][DEPTH];
  logic [WAYS*LINE_W-1:0] rd_data_q;
  logic                   rd_valid_q;
  logic                   misalign_q, misalign_d;

  logic                   commit;
  logic [WAY_W-1:0]       commit_way;
  logic [INDEX-1:0]       commit_index;
  logic [LINE_W-1:0]      commit_line;

  byte_mask_t             bm;
  logic                   unused_mask;
  logic [LINE_B-1:0]      byte_en;
  logic [LINE_W-1:0]      bit_mask;
  logic [LINE_W-1:0]      wdata;
  logic                   st_en;

  dcache_refill_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .INDEX  (INDEX),
    .WAY_W  (WAY_W)
  ) u_refill (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (refill_start),
    .way_i    (refill_way),
    .index_i  (refill_index),
    .valid_i  (refill_valid),
    .data_i   (refill_data),
    .ready_o  (refill_ready),
    .commit_o (commit),
    .way_o    (commit_way),
    .index_o  (commit_index),
    .line_o   (commit_line)
  );

  assign bm          = byte_mask(storesrc_e'(storesrc), MAX_OFF_W'(byte_offset));
  assign byte_en     = bm.mask[LINE_B-1:0];
  assign unused_mask = ^bm.mask;

  // The commit owns the write port for its cycle; stores then are silently dropped.
  assign st_en      = wren && !commit && bm.aligned;
  assign misalign_d = wren && !commit && !bm.aligned;

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < LINE_B; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    end
  end

  always_comb begin
    case (storesrc_e'(storesrc))
      SB:      wdata = {(LINE_W/8){store_data[7:0]}};
      SH:      wdata = {(LINE_W/16){store_data[15:0]}};
      SW:      wdata = {(LINE_W/32){store_data[31:0]}};
      default: wdata = {(LINE_W/64){store_data[63:0]}};
    endcase
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (commit && commit_way == WAY_W'(w)) begin
        mem_q[w][commit_index] <= commit_line;
      end else if (st_en && way_sel == WAY_W'(w)) begin
        mem_q[w][index] <= (mem_q[w][index] & ~bit_mask) | (wdata & bit_mask);
      end
    end
  end

  // Samples the array before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= rden;
      misalign_q <= misalign_d;
      if (rden) begin
        for (int w = 0; w < WAYS; w++) begin
          rd_data_q[w*LINE_W +: LINE_W] <= mem_q[w][index];
        end
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign misalign_err = misalign_q;
  assign busy         = commit;
  assign refill_done  = commit;

endmodule

// File: tb/tb_dcache_data_ways.sv
// Bench for dcache_data_ways: store vector table, refill sequences and read scoreboard.
module tb_dcache_data_ways;

  logic         clk;
  logic         rst;
  logic         rden, wren;
  logic         way_sel;
  logic [9:0]   index;
  logic [3:0]   byte_offset;
  logic [1:0]   storesrc;
  logic [63:0]  store_data;
  logic [255:0] rd_data;
  logic         rd_valid, busy, misalign_err;
  logic         refill_start, refill_way;
  logic [9:0]   refill_index;
  logic         refill_valid;
  logic [31:0]  refill_data;
  logic         refill_ready, refill_done;

  dcache_data_ways dut (
    .clk          (clk),
    .rst          (rst),
    .rden         (rden),
    .wren         (wren),
    .way_sel      (way_sel),
    .index        (index),
    .byte_offset  (byte_offset),
    .storesrc     (storesrc),
    .store_data   (store_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .misalign_err (misalign_err),
    .refill_start (refill_start),
    .refill_way   (refill_way),
    .refill_index (refill_index),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .refill_ready (refill_ready),
    .refill_done  (refill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_FILL, M_COMMIT} mstate_t;

  typedef struct {
    bit          rden;
    bit          wren;
    bit          way;
    logic [9:0]  idx;
    logic [3:0]  off;
    logic [1:0]  src;
    logic [63:0] data;
    bit          exp_mis;
  } vec_t;

  logic [127:0] model [2][1024];
  mstate_t      m_state;
  int           m_cnt;
  logic         m_way;
  logic [9:0]   m_idx;
  logic [127:0] m_buf;
  logic [255:0] rd_q [$];
  logic [255:0] last_rd;
  int           n_tests;
  int           n_fail;
  vec_t         vecs [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit w, bit way, logic [9:0] idx, logic [3:0] off,
                              logic [1:0] src, logic [63:0] data, bit mis);
    vec_t v;
    v.rden = r; v.wren = w; v.way = way; v.idx = idx; v.off = off;
    v.src = src; v.data = data; v.exp_mis = mis;
    return v;
  endfunction

  task automatic idle();
    rden = 0; wren = 0; way_sel = 0; index = '0; byte_offset = '0; storesrc = '0;
    store_data = '0; refill_start = 0; refill_way = 0; refill_index = '0;
    refill_valid = 0; refill_data = '0;
  endtask

  // One clock: checks FSM-visible outputs, updates the model, then checks the edge results.
  task automatic step(input bit exp_mis);
    bit           rd_pend;
    int           size;
    logic [127:0] t;
    chk("refill_ready", 256'(refill_ready), 256'(m_state == M_FILL));
    chk("busy", 256'(busy), 256'(m_state == M_COMMIT));
    chk("refill_done", 256'(refill_done), 256'(m_state == M_COMMIT));
    rd_pend = rden;
    if (rden) rd_q.push_back({model[1][index], model[0][index]});
    if (m_state == M_COMMIT) begin
      model[m_way][m_idx] = m_buf;
      m_state = M_IDLE;
    end else begin
      if (wren) begin
        size = 1 << storesrc;
        if ((int'(byte_offset) % size) == 0) begin
          t = model[way_sel][index];
          for (int k = 0; k < size; k++) t[(int'(byte_offset) + k)*8 +: 8] = store_data[k*8 +: 8];
          model[way_sel][index] = t;
        end
      end
      if (m_state == M_IDLE && refill_start) begin
        m_state = M_FILL; m_cnt = 0; m_way = refill_way; m_idx = refill_index;
      end else if (m_state == M_FILL && refill_valid) begin
        m_buf[m_cnt*32 +: 32] = refill_data;
        m_cnt++;
        if (m_cnt == 4) m_state = M_COMMIT;
      end
    end
    @(posedge clk);
    #1;
    chk("misalign_err", 256'(misalign_err), 256'(exp_mis));
    chk("rd_valid", 256'(rd_valid), 256'(rd_pend));
    if (rd_pend) last_rd = rd_q.pop_front();
    chk("rd_data", rd_data, last_rd);
  endtask

  task automatic st(input bit way, input logic [9:0] idx, input logic [3:0] off,
                    input logic [1:0] src, input logic [63:0] data);
    idle();
    wren = 1; way_sel = way; index = idx; byte_offset = off; storesrc = src; store_data = data;
    step(0);
    idle();
  endtask

  task automatic rd(input logic [9:0] idx);
    idle();
    rden = 1; index = idx;
    step(0);
    idle();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; last_rd = '0; m_state = M_IDLE; m_cnt = 0;
    m_way = 0; m_idx = '0; m_buf = '0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", rd_data, '0);
    chk("reset rd_valid", 256'(rd_valid), '0);
    chk("reset busy", 256'(busy), '0);
    chk("reset misalign_err", 256'(misalign_err), '0);
    chk("reset refill_ready", 256'(refill_ready), '0);
    chk("reset refill_done", 256'(refill_done), '0);
    rst = 0;

    foreach (vecs[i]) vecs.delete(i);
    // Known contents for every line the bench reads back.
    for (int w = 0; w < 2; w++) begin
      st(w[0], 10'd5, 4'd0, 2'd3, 64'h0); st(w[0], 10'd5, 4'd8, 2'd3, 64'h0);
      st(w[0], 10'd6, 4'd0, 2'd3, 64'h0); st(w[0], 10'd6, 4'd8, 2'd3, 64'h0);
      st(w[0], 10'd9, 4'd0, 2'd3, 64'h0); st(w[0], 10'd9, 4'd8, 2'd3, 64'h0);
    end
    st(0, 10'd7, 4'd0, 2'd3, 64'hCCCC_CCCC_CCCC_CCCC); st(0, 10'd7, 4'd8, 2'd3, 64'hCCCC_CCCC_CCCC_CCCC);
    st(1, 10'd7, 4'd0, 2'd3, 64'h5555_5555_5555_5555); st(1, 10'd7, 4'd8, 2'd3, 64'h5555_5555_5555_5555);

    vecs.push_back(mk(0, 1, 1, 10'd5, 4'd8,  2'd3, 64'h1122334455667788, 0));
    vecs.push_back(mk(1, 0, 0, 10'd5, 4'd0,  2'd0, 64'h0, 0));
    vecs.push_back(mk(0, 1, 0, 10'd5, 4'd15, 2'd0, 64'hFFFFFFFFFFFFFFAB, 0));
    vecs.push_back(mk(1, 0, 0, 10'd5, 4'd0,  2'd0, 64'h0, 0));
    vecs.push_back(mk(0, 1, 0, 10'd5, 4'd3,  2'd1, 64'hBEEF, 1));
    vecs.push_back(mk(1, 0, 0, 10'd5, 4'd0,  2'd0, 64'h0, 0));
    vecs.push_back(mk(0, 1, 0, 10'd6, 4'd12, 2'd2, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 1, 10'd6, 4'd2,  2'd1, 64'h1234, 0));
    vecs.push_back(mk(0, 1, 1, 10'd6, 4'd6,  2'd2, 64'hCAFEF00D, 1));
    vecs.push_back(mk(0, 1, 0, 10'd6, 4'd4,  2'd3, 64'h0123456789ABCDEF, 1));
    vecs.push_back(mk(0, 1, 1, 10'd6, 4'd7,  2'd0, 64'h5A, 0));
    vecs.push_back(mk(1, 0, 0, 10'd6, 4'd0,  2'd0, 64'h0, 0));
    vecs.push_back(mk(1, 1, 0, 10'd9, 4'd0,  2'd3, 64'h0123456789ABCDEF, 0));
    vecs.push_back(mk(1, 0, 0, 10'd9, 4'd0,  2'd0, 64'h0, 0));
    vecs.push_back(mk(0, 0, 0, 10'd0, 4'd0,  2'd0, 64'h0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      rden = vecs[i].rden; wren = vecs[i].wren; way_sel = vecs[i].way; index = vecs[i].idx;
      byte_offset = vecs[i].off; storesrc = vecs[i].src; store_data = vecs[i].data;
      step(vecs[i].exp_mis);
    end
    idle();

    rd(10'd5);
    chk("idx5 lines", rd_data, {64'h1122334455667788, 64'h0, 8'hAB, 120'h0});
    rd(10'd9);
    chk("idx9 way0 rmw", rd_data[127:0], {64'h0, 64'h0123456789ABCDEF});

    // Refill way0/idx7 with one valid gap and an ignored restart mid-fill.
    refill_start = 1; refill_way = 0; refill_index = 10'd7; step(0); idle();
    refill_valid = 1; refill_data = 32'hA0; step(0);
    refill_data = 32'hA1; step(0);
    refill_valid = 0; refill_start = 1; refill_way = 1; refill_index = 10'd9; step(0);
    idle(); refill_valid = 1; refill_data = 32'hA2; step(0);
    refill_data = 32'hA3; step(0);
    idle();
    chk("commit busy", 256'(busy), 256'(1));
    wren = 1; way_sel = 1; index = 10'd7; byte_offset = 0; storesrc = 2'd3;
    store_data = 64'h0BAD_0BAD_0BAD_0BAD; rden = 1;
    step(0);
    idle();
    chk("commit read old", rd_data, {{2{64'h5555_5555_5555_5555}}, {2{64'hCCCC_CCCC_CCCC_CCCC}}});
    chk("refill_done after", 256'(refill_done), '0);
    rd(10'd7);
    chk("refilled line", rd_data, {{2{64'h5555_5555_5555_5555}}, 128'h000000A3_000000A2_000000A1_000000A0});

    // Reset after two accepted beats must abandon the refill of way1/idx5.
    refill_start = 1; refill_way = 1; refill_index = 10'd5; step(0); idle();
    refill_valid = 1; refill_data = 32'hB0; step(0);
    refill_data = 32'hB1; step(0);
    refill_valid = 0; rst = 1;
    #1;
    chk("rst refill_ready", 256'(refill_ready), '0);
    chk("rst busy", 256'(busy), '0);
    chk("rst rd_data", rd_data, '0);
    m_state = M_IDLE; last_rd = '0;
    @(posedge clk);
    #1;
    chk("rst refill_done", 256'(refill_done), '0);
    rst = 0;
    refill_valid = 1; refill_data = 32'hB2; step(0);
    refill_data = 32'hB3; step(0);
    idle(); step(0);
    rd(10'd5);
    chk("idx5 after abort", rd_data[255:128], {64'h1122334455667788, 64'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
